// File: rtl/byte_pkg.sv
// Shared definitions for the byte serializer / deserializer pair.
// Frame-size defaults, byte width and the deserializer state encoding.
package byte_pkg;
  localparam int BYTE_W        = 8;
  localparam int DEF_MAX_BYTES = 32;
  localparam int DEF_CNT_W     = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;
endpackage

// File: rtl/byte_deser_if.sv
// Byte-in / frame-out bundle of the deserializer.
// The slave modport is the deserializer side; master is the producer/consumer side.
interface byte_deser_if
  import byte_pkg::*;
#(
  parameter int MAX_BYTES = DEF_MAX_BYTES,
  parameter int CNT_W     = DEF_CNT_W
);
  logic                          begin_frame;
  logic [CNT_W-1:0]              din_bytecount;
  logic [BYTE_W-1:0]             din;
  logic                          din_valid;
  logic [BYTE_W*MAX_BYTES-1:0]   dout;
  logic                          dout_valid;
  logic                          dout_ack;
  logic [CNT_W-1:0]              dout_bytecount;
  logic                          busy;
  logic                          overrun;
  logic                          err;

  modport master (
    output begin_frame, din_bytecount, din, din_valid, dout_ack,
    input  dout, dout_valid, dout_bytecount, busy, overrun, err
  );

  modport slave (
    input  begin_frame, din_bytecount, din, din_valid, dout_ack,
    output dout, dout_valid, dout_bytecount, busy, overrun, err
  );
endinterface

// File: rtl/byte_deser_timer.sv
// Inter-byte timeout counter, built only with BYTE_DESER_TIMEOUT_EN.
// o_expired pulses on the TIMEOUT_CYCLES-th consecutive enabled cycle without i_clear.
`ifdef BYTE_DESER_TIMEOUT_EN
module byte_deser_timer #(
  parameter int TIMEOUT_CYCLES = 1000000
)(
  input  logic clk,
  input  logic reset_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] r_cnt;

  assign o_expired = i_enable && !i_clear && (r_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clear || o_expired) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= r_cnt + TW'(1);
    end
  end
endmodule
`endif

// File: rtl/byte_deser.sv
// Collects a framed run of bytes into one little-endian word, presented with valid/ack; dout_valid 1 cycle after the last byte.
// Optional inter-byte timeout under BYTE_DESER_TIMEOUT_EN; bytes arriving outside COLLECT are dropped and flagged in overrun.
module byte_deser
  import byte_pkg::*;
#(
  parameter int MAX_BYTES = DEF_MAX_BYTES,
  parameter int CNT_W     = DEF_CNT_W
`ifdef BYTE_DESER_TIMEOUT_EN
  ,parameter int TIMEOUT_CYCLES = 1000000
`endif
)(
  input  logic         clk,
  input  logic         reset_n,
  byte_deser_if.slave  bus
);
  localparam int DW = BYTE_W * MAX_BYTES;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_count, w_count_nxt;
  logic [CNT_W-1:0] r_index, w_index_nxt;
  logic [CNT_W-1:0] r_dout_bytecount, w_bytecount_nxt;
  logic [DW-1:0]    r_dout, w_dout_nxt;
  logic             r_dout_valid, w_valid_nxt;
  logic             r_overrun, w_overrun_nxt;
  logic             r_err, w_err_nxt;
  logic             w_cnt_ok, w_last, w_start, w_expired;

  assign w_cnt_ok = (bus.din_bytecount != '0) && (bus.din_bytecount <= CNT_W'(MAX_BYTES));
  assign w_last   = (r_index == r_count - CNT_W'(1));
  assign w_start  = bus.begin_frame && w_cnt_ok &&
                    ((r_state == IDLE) || (r_state == COLLECT) ||
                     ((r_state == DONE) && bus.dout_ack));

`ifdef BYTE_DESER_TIMEOUT_EN
  logic w_tmr_clr;
  logic w_tmr_en;
  assign w_tmr_clr = (r_state != COLLECT) || bus.din_valid || bus.begin_frame;
  assign w_tmr_en  = (r_state == COLLECT);

  byte_deser_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_clear   (w_tmr_clr),
    .i_enable  (w_tmr_en),
    .o_expired (w_expired)
  );
`else
  assign w_expired = 1'b0;
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_count_nxt     = r_count;
    w_index_nxt     = r_index;
    w_bytecount_nxt = r_dout_bytecount;
    w_dout_nxt      = r_dout;
    w_valid_nxt     = r_dout_valid;
    w_overrun_nxt   = r_overrun;
    w_err_nxt       = 1'b0;

    case (r_state)
      IDLE: begin
        if (bus.begin_frame && !w_cnt_ok) w_err_nxt = 1'b1;
      end
      COLLECT: begin
        if (bus.begin_frame) begin
          // any begin_frame here aborts the partial frame; a bad count also drops to IDLE
          w_err_nxt = 1'b1;
          if (!w_cnt_ok) begin
            w_state_nxt = IDLE;
            w_dout_nxt  = '0;
          end
        end else if (bus.din_valid) begin
          for (int k = 0; k < MAX_BYTES; k++) begin
            if (r_index == CNT_W'(k)) w_dout_nxt[k*BYTE_W +: BYTE_W] = bus.din;
          end
          if (w_last) begin
            w_state_nxt     = DONE;
            w_valid_nxt     = 1'b1;
            w_bytecount_nxt = r_count;
          end else begin
            w_index_nxt = r_index + CNT_W'(1);
          end
        end else if (w_expired) begin
          w_err_nxt   = 1'b1;
          w_dout_nxt  = '0;
          w_state_nxt = IDLE;
        end
      end
      DONE: begin
        if (bus.dout_ack) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = IDLE;
          if (bus.begin_frame && !w_cnt_ok) w_err_nxt = 1'b1;
        end else if (bus.begin_frame) begin
          w_err_nxt = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    if (w_start) begin
      w_state_nxt   = COLLECT;
      w_count_nxt   = bus.din_bytecount;
      w_index_nxt   = '0;
      w_dout_nxt    = '0;
      w_overrun_nxt = 1'b0;
    end

    // a byte is accepted only in COLLECT without a competing begin_frame
    if (bus.din_valid && !((r_state == COLLECT) && !bus.begin_frame)) w_overrun_nxt = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state          <= IDLE;
      r_count          <= '0;
      r_index          <= '0;
      r_dout_bytecount <= '0;
      r_dout           <= '0;
      r_dout_valid     <= 1'b0;
      r_overrun        <= 1'b0;
      r_err            <= 1'b0;
    end else begin
      r_state          <= w_state_nxt;
      r_count          <= w_count_nxt;
      r_index          <= w_index_nxt;
      r_dout_bytecount <= w_bytecount_nxt;
      r_dout           <= w_dout_nxt;
      r_dout_valid     <= w_valid_nxt;
      r_overrun        <= w_overrun_nxt;
      r_err            <= w_err_nxt;
    end
  end

  assign bus.dout           = r_dout;
  assign bus.dout_valid     = r_dout_valid;
  assign bus.dout_bytecount = r_dout_bytecount;
  assign bus.busy           = (r_state == COLLECT);
  assign bus.overrun        = r_overrun;
  assign bus.err            = r_err;
endmodule

// File: tb/tb_byte_deser.sv
// Bench for byte_deser: frame-level reference model compared every cycle, plus directed literal checks.
module tb_byte_deser;
  import byte_pkg::*;

  localparam int MB = DEF_MAX_BYTES;
  localparam int CW = DEF_CNT_W;
  localparam int DW = 8 * MB;
`ifdef BYTE_DESER_TIMEOUT_EN
  localparam int TO = 16;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;
  bit   chk_en      = 1'b0;

  byte_deser_if #(.MAX_BYTES(MB), .CNT_W(CW)) bus ();

  byte_deser #(
    .MAX_BYTES(MB),
    .CNT_W(CW)
`ifdef BYTE_DESER_TIMEOUT_EN
    ,.TIMEOUT_CYCLES(TO)
`endif
  ) dut (
    .clk     (clk),
    .reset_n (rst_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: frame as a byte queue; phase 0 idle, 1 collecting, 2 presenting.
  int          m_phase = 0;
  int          m_want  = 0;
  int          m_stall = 0;
  logic [7:0]  m_bytes[$];
  bit          m_vld = 1'b0;
  bit          m_ovr = 1'b0;
  bit          m_err = 1'b0;
  logic [CW-1:0] m_obc = '0;

  function automatic logic [DW-1:0] m_word();
    logic [DW-1:0] r = '0;
    foreach (m_bytes[i]) r[8*i +: 8] = m_bytes[i];
    return r;
  endfunction

  task automatic m_reset();
    m_phase = 0; m_want = 0; m_stall = 0; m_bytes.delete();
    m_vld = 1'b0; m_ovr = 1'b0; m_err = 1'b0; m_obc = '0;
  endtask

  task automatic m_start(input int n);
    m_want = n; m_bytes.delete(); m_phase = 1; m_ovr = 1'b0; m_stall = 0;
  endtask

  task automatic m_step();
    bit bf  = bus.begin_frame;
    int n   = int'(bus.din_bytecount);
    bit ok  = (n >= 1) && (n <= MB);
    bit dv  = bus.din_valid;
    int p0  = m_phase;
    m_err = 1'b0;
    if (p0 == 0) begin
      if (bf) begin
        if (ok) m_start(n); else m_err = 1'b1;
      end
    end else if (p0 == 1) begin
      if (bf) begin
        m_err = 1'b1;
        if (ok) m_start(n);
        else begin m_phase = 0; m_bytes.delete(); end
      end else if (dv) begin
        m_bytes.push_back(bus.din);
        m_stall = 0;
        if (m_bytes.size() == m_want) begin
          m_phase = 2; m_vld = 1'b1; m_obc = CW'(m_want);
        end
      end else begin
`ifdef BYTE_DESER_TIMEOUT_EN
        m_stall++;
        if (m_stall == TO) begin
          m_err = 1'b1; m_bytes.delete(); m_phase = 0;
        end
`endif
      end
    end else begin
      if (bus.dout_ack) begin
        m_vld = 1'b0; m_phase = 0;
        if (bf) begin
          if (ok) m_start(n); else m_err = 1'b1;
        end
      end else if (bf) begin
        m_err = 1'b1;
      end
    end
    if (dv && !(p0 == 1 && !bf)) m_ovr = 1'b1;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) m_reset();
    else        m_step();
  end

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("dout",           bus.dout,                m_word());
      chk("dout_valid",     DW'(bus.dout_valid),     DW'(m_vld));
      chk("dout_bytecount", DW'(bus.dout_bytecount), DW'(m_obc));
      chk("busy",           DW'(bus.busy),           DW'(m_phase == 1));
      chk("overrun",        DW'(bus.overrun),        DW'(m_ovr));
      chk("err",            DW'(bus.err),            DW'(m_err));
    end
  end

  task automatic set_in(input bit bf, input int n, input bit dv, input logic [7:0] d, input bit ack);
    bus.begin_frame   = bf;
    bus.din_bytecount = CW'(n);
    bus.din_valid     = dv;
    bus.din           = d;
    bus.dout_ack      = ack;
  endtask

  task automatic step(input bit bf, input int n, input bit dv, input logic [7:0] d, input bit ack);
    set_in(bf, n, dv, d, ack);
    @(negedge clk);
  endtask

  task automatic lit_zero(input string tag);
    chk({tag, "_dout"},  bus.dout,                '0);
    chk({tag, "_vld"},   DW'(bus.dout_valid),     '0);
    chk({tag, "_bc"},    DW'(bus.dout_bytecount), '0);
    chk({tag, "_busy"},  DW'(bus.busy),           '0);
    chk({tag, "_ovr"},   DW'(bus.overrun),        '0);
    chk({tag, "_err"},   DW'(bus.err),            '0);
  endtask

  initial begin
    logic [DW-1:0] e;
    int bad[2] = '{0, 33};
    set_in(0, 0, 0, 8'h00, 0);
    repeat (3) @(negedge clk);
    lit_zero("reset");
    rst_n  = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    // reset in the middle of a frame
    step(1, 4, 0, 8'h00, 0);
    step(0, 0, 1, 8'hA1, 0);
    step(0, 0, 1, 8'hA2, 0);
    chk("mid_busy", DW'(bus.busy), DW'(1));
    set_in(0, 0, 0, 8'h00, 0);
    #2 rst_n = 1'b0;
    #1 lit_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 4-byte frame
    step(1, 4, 0, 8'h00, 0);
    step(0, 0, 1, 8'h11, 0);
    step(0, 0, 1, 8'h22, 0);
    step(0, 0, 1, 8'h33, 0);
    chk("f4_vld_early", DW'(bus.dout_valid), DW'(0));
    step(0, 0, 1, 8'h44, 0);
    chk("f4_vld",   DW'(bus.dout_valid), DW'(1));
    chk("f4_word",  DW'(bus.dout[31:0]), DW'(32'h44332211));
    chk("f4_upper", DW'(bus.dout[DW-1:32]), '0);
    chk("f4_bc",    DW'(bus.dout_bytecount), DW'(4));
    repeat (3) step(0, 0, 0, 8'h00, 0);
    chk("f4_hold",  DW'(bus.dout_valid), DW'(1));
    step(0, 0, 0, 8'h00, 1);
    chk("f4_acked", DW'(bus.dout_valid), DW'(0));
    chk("f4_keep",  DW'(bus.dout[31:0]), DW'(32'h44332211));

    // full 32-byte frame, back to back
    step(1, 32, 0, 8'h00, 0);
    for (int k = 0; k < 32; k++) step(0, 0, 1, 8'(k), 0);
    e = '0;
    for (int k = 0; k < 32; k++) e[8*k +: 8] = 8'(k);
    chk("f32_word", bus.dout, e);
    chk("f32_ovr",  DW'(bus.overrun), DW'(0));
    chk("f32_bc",   DW'(bus.dout_bytecount), DW'(32));
    step(0, 0, 0, 8'h00, 1);

    // illegal counts
    foreach (bad[i]) begin
      step(1, bad[i], 0, 8'h00, 0);
      chk("bad_err",  DW'(bus.err),  DW'(1));
      chk("bad_busy", DW'(bus.busy), DW'(0));
      step(0, 0, 0, 8'h00, 0);
      chk("bad_err_clr", DW'(bus.err), DW'(0));
    end

    // dropped byte in IDLE, then a 2-byte frame
    step(0, 0, 1, 8'hAA, 0);
    chk("ovr_set", DW'(bus.overrun), DW'(1));
    step(1, 2, 0, 8'h00, 0);
    chk("ovr_clr", DW'(bus.overrun), DW'(0));
    step(0, 0, 1, 8'h5A, 0);
    step(0, 0, 1, 8'hC3, 0);
    chk("f2_word", DW'(bus.dout[15:0]), DW'(16'hC35A));
    chk("f2_vld",  DW'(bus.dout_valid), DW'(1));
    step(0, 0, 0, 8'h00, 1);

    // abort and restart
    step(1, 3, 0, 8'h00, 0);
    step(0, 0, 1, 8'h01, 0);
    step(1, 3, 0, 8'h00, 0);
    chk("abort_err",  DW'(bus.err), DW'(1));
    chk("abort_dout", bus.dout, '0);
    step(0, 0, 1, 8'h0A, 0);
    step(0, 0, 1, 8'h0B, 0);
    step(0, 0, 1, 8'h0C, 0);
    chk("abort_word", bus.dout, DW'(24'h0C0B0A));
    step(0, 0, 0, 8'h00, 1);

`ifdef BYTE_DESER_TIMEOUT_EN
    step(1, 4, 0, 8'h00, 0);
    step(0, 0, 1, 8'h77, 0);
    repeat (TO - 1) step(0, 0, 0, 8'h00, 0);
    chk("to_wait", DW'(bus.busy), DW'(1));
    step(0, 0, 0, 8'h00, 0);
    chk("to_busy", DW'(bus.busy), DW'(0));
    chk("to_err",  DW'(bus.err),  DW'(1));
    chk("to_dout", bus.dout, '0);
`endif

    // randomized traffic against the model
    repeat (3000) begin
      step($urandom_range(0, 99) < 6, int'($urandom_range(0, 36)),
           $urandom_range(0, 99) < 60, 8'($urandom), $urandom_range(0, 99) < 30);
    end
    set_in(0, 0, 0, 8'h00, 0);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/byte_deser.md
Name: byte_deser

Overview:
- Receive-side counterpart of the transmit byte serializer.
- Collects a framed run of bytes, as delivered by the UART receiver after resynchronisation into clk, into one wide little-endian word.
- Presents the word to the command/test logic with a valid/ack handshake.
- Frame length is loaded at frame start. One frame buffered; no FIFO.

Parameters:
- MAX_BYTES, 32, maximum frame length in bytes; dout width is 8*MAX_BYTES.
- CNT_W, 6, width of byte counts; must satisfy 2**CNT_W > MAX_BYTES.
- TIMEOUT_CYCLES, 1000000, inter-byte timeout in clk cycles (optional feature only).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- begin_frame  in  1  1-cycle pulse: start a frame of din_bytecount bytes.
- din_bytecount  in  CNT_W  expected byte count; sampled only when begin_frame=1.
- din  in  8  received byte.
- din_valid  in  1  1-cycle strobe, din valid.
- dout  out  8*MAX_BYTES  assembled frame; byte k at dout[8k+7:8k].
- dout_valid  out  1  frame complete, held until acknowledged.
- dout_ack  in  1  consumer accepts frame.
- dout_bytecount  out  CNT_W  bytes in the presented frame.
- busy  out  1  high in COLLECT.
- overrun  out  1  sticky: a byte was dropped.
- err  out  1  1-cycle pulse on protocol error.

Behaviour:
- Reset (async assert, sync release) drives:
  - state=IDLE;
  - dout=0, dout_valid=0, dout_bytecount=0;
  - busy=0, overrun=0, err=0;
  - internal index=0.
- State machine: IDLE -> COLLECT -> DONE -> IDLE.
- IDLE:
  - begin_frame with 1 <= din_bytecount <= MAX_BYTES: latch count, clear dout to 0, index=0, clear overrun, go COLLECT next cycle.
  - begin_frame with count 0 or > MAX_BYTES: pulse err, stay IDLE.
  - din_valid: byte dropped, overrun=1.
- COLLECT:
  - On din_valid: write din into byte lane [index], index+1.
  - When the accepted byte is the last one (index == count-1): go DONE.
  - On entering DONE (the cycle after the last byte): dout_valid=1 and dout_bytecount=count.
  - Unfilled upper lanes remain 0.
- begin_frame in COLLECT:
  - Aborts the partial frame, pulses err, restarts with the new count (same validity rules).
  - Invalid count: return to IDLE.
  - A din_valid in the same cycle is dropped (overrun=1).
- DONE:
  - dout and dout_bytecount are stable while dout_valid=1.
  - dout_ack: dout_valid=0, go IDLE next cycle. dout holds its value until the next begin_frame.
  - din_valid in DONE: dropped, overrun=1.
  - begin_frame in DONE without dout_ack: ignored, err pulse.
  - begin_frame with dout_ack in the same cycle: ack completes and the new frame starts (go COLLECT, dout cleared).
- Latency: last byte strobe to dout_valid is 1 cycle. A back-to-back din_valid on every cycle is legal.
- busy = (state==COLLECT). err is registered, never high for 2 consecutive cycles from a single event.
- Index never exceeds count-1, so no lane wrap-around is possible.

Optional Feature:
- Macro BYTE_DESER_TIMEOUT_EN.
- Defined:
  - An inter-byte counter runs in COLLECT. It is reset on entry and on every accepted byte.
  - On reaching TIMEOUT_CYCLES with no byte: pulse err, discard the partial frame (dout cleared), go IDLE.
  - The counter is idle outside COLLECT.
- Undefined: no counter. COLLECT waits indefinitely; only begin_frame or reset leaves it early.

Decomposition:
- Shared package byte_pkg holds:
  - MAX_BYTES and CNT_W defaults, shared with the serializer;
  - state enum (IDLE, COLLECT, DONE);
  - BYTE_W=8.
- No sub-module is needed.
- When BYTE_DESER_TIMEOUT_EN is defined, the timeout counter is a natural small sub-module, byte_deser_timer (clear, enable, expired).

Test Plan:
- Reset mid-COLLECT (after 2 of 4 bytes): all outputs 0 immediately; a later 4-byte frame assembles correctly.
- begin_frame count=4, bytes 0x11,0x22,0x33,0x44 -> dout[31:0]=0x44332211, upper lanes 0, dout_bytecount=4, dout_valid 1 cycle after 0x44; held until dout_ack.
- Count=32, 32 back-to-back strobes of 0x00..0x1F -> dout byte k = k; no overrun.
- Count=0 and count=33 -> err pulse each, state stays IDLE, busy=0.
- din_valid=0xAA while IDLE, then a 2-byte frame -> overrun=1 after 0xAA, cleared by begin_frame, frame correct.
- Abort and timeout:
  - begin_frame count=3 after 1 byte -> err, new frame of 3 bytes assembles with only the new bytes.
  - With BYTE_DESER_TIMEOUT_EN and TIMEOUT_CYCLES=16, stall 16 cycles mid-frame -> err, return to IDLE.
